// File: rtl/cc_demux_pkg.sv
// cc_demux_pkg: shared constants and slot state encoding for the 1:2 demux.
package cc_demux_pkg;

  localparam int CC_DEMUX_DATAWIDTH_DEF  = 8;
  localparam int CC_DEMUX_COUNTWIDTH_DEF = 16;

  localparam logic CC_DEMUX_SEL_CH1 = 1'b0;
  localparam logic CC_DEMUX_SEL_CH2 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/cc_demux_slot.sv
// cc_demux_slot: one-entry output register with valid/ready handshake.
// Optional delivered-word counter built when CC_DEMUX_12_COUNT_EN is defined.
//
// state      | meaning
// SLOT_EMPTY | no word held, valid low
// SLOT_FULL  | word held stable until the consumer takes it
module cc_demux_slot
  import cc_demux_pkg::*;
#(
  parameter int DW = CC_DEMUX_DATAWIDTH_DEF,
  parameter int CW = CC_DEMUX_COUNTWIDTH_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_slot_ready
`ifdef CC_DEMUX_12_COUNT_EN
  ,
  output logic [CW-1:0] o_count
`endif
);

  slot_state_t   r_state;
  logic [DW-1:0] r_data;
  logic          w_take;

  assign w_take       = (r_state == SLOT_FULL) & i_ready;
  assign o_slot_ready = (r_state == SLOT_EMPTY) | i_ready;
  assign o_valid      = (r_state == SLOT_FULL);
  assign o_data       = r_data;

  // Slot FSM: a load wins over a drain, which gives back-to-back refill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= SLOT_FULL;
      r_data  <= i_data;
    end else if (w_take) begin
      r_state <= SLOT_EMPTY;
    end
  end

`ifdef CC_DEMUX_12_COUNT_EN
  logic [CW-1:0] r_count;

  assign o_count = r_count;

  // Delivered-word counter, wraps naturally at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_take) begin
      r_count <= r_count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/cc_demux_12.sv
// cc_demux_12: registered 1:2 demultiplexer with per-channel valid/ready.
// Define CC_DEMUX_12_COUNT_EN to build the per-channel delivered-word counters.
module cc_demux_12
  import cc_demux_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH  = CC_DEMUX_DATAWIDTH_DEF,
  parameter int NUMBER_COUNTWIDTH = CC_DEMUX_COUNTWIDTH_DEF
) (
  input  logic                        CC_DEMUX_12_CLOCK_50,
  input  logic                        CC_DEMUX_12_RESET_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_DEMUX_12_data_InBUS,
  input  logic                        CC_DEMUX_12_select_InBUS,
  input  logic                        CC_DEMUX_12_valid_In,
  output logic                        CC_DEMUX_12_ready_Out,
  output logic [NUMBER_DATAWIDTH-1:0] CC_DEMUX_12_data1_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] CC_DEMUX_12_data2_OutBUS,
  output logic                        CC_DEMUX_12_valid1_Out,
  output logic                        CC_DEMUX_12_valid2_Out,
  input  logic                        CC_DEMUX_12_ready1_In,
  input  logic                        CC_DEMUX_12_ready2_In
`ifdef CC_DEMUX_12_COUNT_EN
  ,
  output logic [NUMBER_COUNTWIDTH-1:0] CC_DEMUX_12_count1_OutBUS,
  output logic [NUMBER_COUNTWIDTH-1:0] CC_DEMUX_12_count2_OutBUS
`endif
);

  logic w_rdy1;
  logic w_rdy2;
  logic w_accept;
  logic w_load1;
  logic w_load2;

  // Ready follows only the addressed slot, so a stalled channel blocks only its own traffic.
  always_comb begin
    CC_DEMUX_12_ready_Out = (CC_DEMUX_12_select_InBUS == CC_DEMUX_SEL_CH2) ? w_rdy2 : w_rdy1;
  end

  assign w_accept = CC_DEMUX_12_valid_In & CC_DEMUX_12_ready_Out;
  assign w_load1  = w_accept & (CC_DEMUX_12_select_InBUS == CC_DEMUX_SEL_CH1);
  assign w_load2  = w_accept & (CC_DEMUX_12_select_InBUS == CC_DEMUX_SEL_CH2);

  cc_demux_slot #(
    .DW(NUMBER_DATAWIDTH),
    .CW(NUMBER_COUNTWIDTH)
  ) u_slot1 (
    .i_clk        (CC_DEMUX_12_CLOCK_50),
    .i_rst_n      (CC_DEMUX_12_RESET_InLow),
    .i_load       (w_load1),
    .i_data       (CC_DEMUX_12_data_InBUS),
    .i_ready      (CC_DEMUX_12_ready1_In),
    .o_valid      (CC_DEMUX_12_valid1_Out),
    .o_data       (CC_DEMUX_12_data1_OutBUS),
    .o_slot_ready (w_rdy1)
`ifdef CC_DEMUX_12_COUNT_EN
    ,
    .o_count      (CC_DEMUX_12_count1_OutBUS)
`endif
  );

  cc_demux_slot #(
    .DW(NUMBER_DATAWIDTH),
    .CW(NUMBER_COUNTWIDTH)
  ) u_slot2 (
    .i_clk        (CC_DEMUX_12_CLOCK_50),
    .i_rst_n      (CC_DEMUX_12_RESET_InLow),
    .i_load       (w_load2),
    .i_data       (CC_DEMUX_12_data_InBUS),
    .i_ready      (CC_DEMUX_12_ready2_In),
    .o_valid      (CC_DEMUX_12_valid2_Out),
    .o_data       (CC_DEMUX_12_data2_OutBUS),
    .o_slot_ready (w_rdy2)
`ifdef CC_DEMUX_12_COUNT_EN
    ,
    .o_count      (CC_DEMUX_12_count2_OutBUS)
`endif
  );

endmodule

// File: tb/tb_cc_demux_12.sv
// tb_cc_demux_12: table vectors plus hand sequences, with per-channel scoreboards.
module tb_cc_demux_12;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        sel_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic        valid1;
  logic        valid2;
  logic        rdy1;
  logic        rdy2;
`ifdef CC_DEMUX_12_COUNT_EN
  logic [15:0] count1;
  logic [15:0] count2;
`endif

  cc_demux_12 #(
    .NUMBER_DATAWIDTH (8),
    .NUMBER_COUNTWIDTH(16)
  ) dut (
    .CC_DEMUX_12_CLOCK_50    (clk),
    .CC_DEMUX_12_RESET_InLow (rst_n),
    .CC_DEMUX_12_data_InBUS  (data_in),
    .CC_DEMUX_12_select_InBUS(sel_in),
    .CC_DEMUX_12_valid_In    (valid_in),
    .CC_DEMUX_12_ready_Out   (ready_out),
    .CC_DEMUX_12_data1_OutBUS(data1),
    .CC_DEMUX_12_data2_OutBUS(data2),
    .CC_DEMUX_12_valid1_Out  (valid1),
    .CC_DEMUX_12_valid2_Out  (valid2),
    .CC_DEMUX_12_ready1_In   (rdy1),
    .CC_DEMUX_12_ready2_In   (rdy2)
`ifdef CC_DEMUX_12_COUNT_EN
    ,
    .CC_DEMUX_12_count1_OutBUS(count1),
    .CC_DEMUX_12_count2_OutBUS(count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       sel;
    logic [7:0] d;
    logic       r1;
    logic       r2;
    logic       e_rdy;
    logic       e_v1;
    logic       e_v2;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int          n_chk = 0;
  int          n_err = 0;
  logic        m_v1, m_v2;
  logic [7:0]  m_d1, m_d2;
  logic [15:0] m_c1, m_c2;
  logic        s_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v1 = 1'b0; m_v2 = 1'b0;
    m_d1 = 8'h00; m_d2 = 8'h00;
    m_c1 = 16'h0; m_c2 = 16'h0;
    q1.delete(); q2.delete();
  endtask

  task automatic chk_reset_values();
    chk("rst_valid1", {31'b0, valid1}, 32'd0);
    chk("rst_valid2", {31'b0, valid2}, 32'd0);
    chk("rst_data1", {24'b0, data1}, 32'd0);
    chk("rst_data2", {24'b0, data2}, 32'd0);
    chk("rst_ready_out", {31'b0, ready_out}, 32'd1);
`ifdef CC_DEMUX_12_COUNT_EN
    chk("rst_count1", {16'b0, count1}, 32'd0);
    chk("rst_count2", {16'b0, count2}, 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, check ready, update model/scoreboard, check after posedge.
  task automatic cycle(input logic v, input logic sel, input logic [7:0] d,
                       input logic r1, input logic r2);
    logic       e_rdy;
    logic [7:0] got;
    @(negedge clk);
    valid_in = v; sel_in = sel; data_in = d; rdy1 = r1; rdy2 = r2;
    #1;
    e_rdy = sel ? (!m_v2 || r2) : (!m_v1 || r1);
    chk("ready_out", {31'b0, ready_out}, {31'b0, e_rdy});
    s_rdy = ready_out;
    if (m_v1 && r1) begin
      if (q1.size() == 0) chk("sb1_underflow", 32'd1, 32'd0);
      else begin
        got = q1.pop_front();
        chk("ch1_delivered", {24'b0, data1}, {24'b0, got});
      end
      m_c1 = m_c1 + 16'd1;
      m_v1 = 1'b0;
    end
    if (m_v2 && r2) begin
      if (q2.size() == 0) chk("sb2_underflow", 32'd1, 32'd0);
      else begin
        got = q2.pop_front();
        chk("ch2_delivered", {24'b0, data2}, {24'b0, got});
      end
      m_c2 = m_c2 + 16'd1;
      m_v2 = 1'b0;
    end
    if (v && e_rdy) begin
      if (sel) begin q2.push_back(d); m_v2 = 1'b1; m_d2 = d; end
      else     begin q1.push_back(d); m_v1 = 1'b1; m_d1 = d; end
    end
    @(posedge clk);
    #1;
    chk("valid1", {31'b0, valid1}, {31'b0, m_v1});
    chk("valid2", {31'b0, valid2}, {31'b0, m_v2});
    if (m_v1) chk("data1", {24'b0, data1}, {24'b0, m_d1});
    if (m_v2) chk("data2", {24'b0, data2}, {24'b0, m_d2});
`ifdef CC_DEMUX_12_COUNT_EN
    chk("count1", {16'b0, count1}, {16'b0, m_c1});
    chk("count2", {16'b0, count2}, {16'b0, m_c2});
`endif
  endtask

  function automatic vec_t mk(input logic v, input logic sel, input logic [7:0] d,
                              input logic r1, input logic r2, input logic e_rdy,
                              input logic e_v1, input logic e_v2,
                              input logic [7:0] e_d1, input logic [7:0] e_d2);
    vec_t t;
    t.v = v; t.sel = sel; t.d = d; t.r1 = r1; t.r2 = r2;
    t.e_rdy = e_rdy; t.e_v1 = e_v1; t.e_v2 = e_v2; t.e_d1 = e_d1; t.e_d2 = e_d2;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; sel_in = 1'b0; data_in = 8'h00; rdy1 = 1'b0; rdy2 = 1'b0;
    model_reset();

    // Vectors from reset: idle, ignored data, capture A5, 10-cycle stall, blocked/bypass, drains.
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, 8'hA5, 0, 0, 1, 1, 0, 8'hA5, 8'h00));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 8'hA5, 8'h00));
    tbl.push_back(mk(1, 0, 8'h3C, 0, 0, 0, 1, 0, 8'hA5, 8'h00));
    tbl.push_back(mk(1, 1, 8'h3C, 0, 0, 1, 1, 1, 8'hA5, 8'h3C));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 1, 8'h00, 8'h3C));
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h00, 8'h00));

    #12;
    chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r1, tbl[i].r2);
      chk($sformatf("tbl%0d_ready", i), {31'b0, s_rdy}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_valid1", i), {31'b0, valid1}, {31'b0, tbl[i].e_v1});
      chk($sformatf("tbl%0d_valid2", i), {31'b0, valid2}, {31'b0, tbl[i].e_v2});
      if (tbl[i].e_v1) chk($sformatf("tbl%0d_data1", i), {24'b0, data1}, {24'b0, tbl[i].e_d1});
      if (tbl[i].e_v2) chk($sformatf("tbl%0d_data2", i), {24'b0, data2}, {24'b0, tbl[i].e_d2});
    end

    // Stream 01..08 to channel 2 with its consumer always ready: valid2 must stay high.
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 1, 8'(i), 0, 1);
      chk("stream_nobubble", {31'b0, valid2}, 32'd1);
      chk("stream_word", {24'b0, data2}, i);
    end
    cycle(0, 1, 8'h00, 0, 1);
    chk("stream_drained", {31'b0, valid2}, 32'd0);
`ifdef CC_DEMUX_12_COUNT_EN
    chk("stream_count2", {16'b0, count2}, 32'd9);
`endif

    // Drain channel 1 while filling channel 2, then drain-and-refill channel 1.
    cycle(1, 0, 8'h11, 0, 0);
    cycle(1, 1, 8'h22, 1, 0);
    chk("drainfill_v1", {31'b0, valid1}, 32'd0);
    chk("drainfill_d2", {24'b0, data2}, 32'h22);
    cycle(1, 0, 8'h33, 0, 0);
    cycle(1, 0, 8'h44, 1, 0);
    chk("refill_ready", {31'b0, s_rdy}, 32'd1);
    chk("refill_d1", {24'b0, data1}, 32'h44);
    cycle(0, 0, 8'h00, 1, 1);
    chk("sb1_empty", q1.size(), 32'd0);
    chk("sb2_empty", q2.size(), 32'd0);

`ifdef CC_DEMUX_12_COUNT_EN
    // Walk count1 up to all-ones, then one more delivery must wrap it to zero.
    while (m_c1 != 16'hFFFF) cycle(1, 0, m_c1[7:0], 1, 0);
    chk("count1_ffff", {16'b0, count1}, 32'h0000FFFF);
    cycle(0, 0, 8'h00, 1, 0);
    chk("count1_wrap", {16'b0, count1}, 32'h00000000);
`endif

    // Fill both slots, then reset asynchronously mid-cycle.
    cycle(1, 0, 8'h55, 0, 0);
    cycle(1, 1, 8'h66, 0, 0);
    chk("pre_rst_v1", {31'b0, valid1}, 32'd1);
    chk("pre_rst_v2", {31'b0, valid2}, 32'd1);
    valid_in = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 8'h00, 0, 0);
    cycle(1, 1, 8'h77, 0, 0);
    chk("post_rst_d2", {24'b0, data2}, 32'h77);
    cycle(0, 0, 8'h00, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
